// File: rtl/display_scan_ctrl_if.sv
// Board-side bundle of the display scan controller: button bank in, digit enables,
// segment bus, cursor and edit strobe out.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 2
);
  logic [7:0]        b;
  logic [DIGITS-1:0] gnd;
  logic [7:0]        leds;
  logic [1:0]        cursor;
  logic              edit_strobe;

  // master: the scan controller; slave: the board (buttons, LED pins)
  modport master (input b, output gnd, output leds, output cursor, output edit_strobe);
  modport slave  (output b, input gnd, input leds, input cursor, input edit_strobe);
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed LED digit scanner with debounced single-button image editing.
// Define SCAN_BLANK_EN to insert an all-off BLANK slot between digits.
module display_scan_ctrl #(
  parameter int DIGITS    = 2,
  parameter int SLOT_CYC  = 128,
  parameter int BLANK_CYC = 8,
  parameter int DEB_BITS  = 21
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.master bus
);

  localparam int CNT_MAX = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif
  localparam logic [1:0] DIGIT_LAST = 2'(DIGITS - 1);

  typedef enum logic {ACTIVE, BLANK} scan_state_t;

  scan_state_t       state_reg, state_next;
  logic [1:0]        digit_reg, digit_next;
  logic [1:0]        digit_inc;
  logic [CNT_W-1:0]  slot_cnt_reg, slot_cnt_next;

  logic [DEB_BITS-1:0] presc_reg;
  logic                tick;
  logic                valid_press;
  logic                accept;
  logic                armed_reg;
  logic                cursor_move;
  logic                seg_toggle;
  logic [6:0]          toggle_mask;
  logic [1:0]          cursor_reg;
  logic                edit_strobe_reg;

  logic [6:0]        img  [4];
  logic [7:0]        disp [4];
  logic [DIGITS-1:0] gnd;
  logic [7:0]        leds;

  // ---------------- scan FSM ----------------
  assign digit_inc = (digit_reg == DIGIT_LAST) ? 2'd0 : digit_reg + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ACTIVE;
      digit_reg    <= 2'd0;
      slot_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      digit_reg    <= digit_next;
      slot_cnt_reg <= slot_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    digit_next    = digit_reg;
    slot_cnt_next = slot_cnt_reg + CNT_W'(1);
    case (state_reg)
      ACTIVE: begin
        if (slot_cnt_reg == SLOT_LAST) begin
          slot_cnt_next = '0;
`ifdef SCAN_BLANK_EN
          state_next    = BLANK;
`else
          digit_next    = digit_inc;
`endif
        end
      end
      BLANK: begin
`ifdef SCAN_BLANK_EN
        if (slot_cnt_reg == BLANK_LAST) begin
          slot_cnt_next = '0;
          state_next    = ACTIVE;
          digit_next    = digit_inc;
        end
`else
        slot_cnt_next = '0;
        state_next    = ACTIVE;
`endif
      end
      default: begin
        state_next    = ACTIVE;
        slot_cnt_next = '0;
      end
    endcase
  end

  // ---------------- button sampling ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + DEB_BITS'(1);
    end
  end

  assign tick        = &presc_reg;
  assign valid_press = ($countones(bus.b) == 7);
  assign accept      = tick && valid_press && armed_reg;
  assign cursor_move = accept && !bus.b[7];
  assign seg_toggle  = accept && bus.b[7];
  assign toggle_mask = ~bus.b[6:0];

  // Any valid sample disarms (accepted or held); anything else re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg       <= 1'b1;
      cursor_reg      <= 2'd0;
      edit_strobe_reg <= 1'b0;
    end else begin
      if (tick) begin
        armed_reg <= !valid_press;
      end
      if (cursor_move) begin
        cursor_reg <= (cursor_reg == DIGIT_LAST) ? 2'd0 : cursor_reg + 2'd1;
      end
      edit_strobe_reg <= accept;
    end
  end

  // ---------------- per-digit images and decode ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      if (gi < DIGITS) begin : g_used
        logic [6:0] img_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            img_reg <= 7'h00;
          end else if (seg_toggle && (cursor_reg == 2'(gi))) begin
            img_reg <= img_reg ^ toggle_mask;
          end
        end
        assign img[gi] = img_reg;
        assign gnd[gi] = (state_reg == ACTIVE) && (digit_reg == 2'(gi));
      end else begin : g_unused
        assign img[gi] = 7'h00;
      end
      assign disp[gi] = {(cursor_reg == 2'(gi)), img[gi]};
    end
  endgenerate

  assign leds = (state_reg == ACTIVE) ? disp[digit_reg] : 8'h00;

  assign bus.gnd         = gnd;
  assign bus.leds        = leds;
  assign bus.cursor      = cursor_reg;
  assign bus.edit_strobe = edit_strobe_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a scoreboard of expected edit results.
module tb_display_scan_ctrl;
  localparam int DIGITS    = 2;
  localparam int SLOT_CYC  = 4;
  localparam int BLANK_CYC = 2;
  localparam int DEB_BITS  = 4;
  localparam int TICK_CYC  = 1 << DEB_BITS;

  typedef struct packed {
    logic [1:0] cursor;
    logic [6:0] img1;
    logic [6:0] img0;
  } view_t;

  typedef struct packed {
    logic [1:0] gnd;
    logic [7:0] leds;
  } scan_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    passed = 0;
  int    total  = 0;
  view_t sb_q[$];
  view_t cur;
  view_t mdl;
  scan_t scan_q[$];

  display_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  display_scan_ctrl #(
    .DIGITS(DIGITS), .SLOT_CYC(SLOT_CYC), .BLANK_CYC(BLANK_CYC), .DEB_BITS(DEB_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    bus.b = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cur = '0;
    mdl = '0;
    sb_q.delete();
  endtask

  // Hold bv for ticks*TICK_CYC cycles (exactly that many button samples) while
  // checking every cycle against the scoreboard's expected view.
  task automatic press(input logic [7:0] bv, input bit accept, input int ticks);
    logic [7:0] exp_leds;
    if (accept) begin
      if (!bv[7]) mdl.cursor = (mdl.cursor == 2'(DIGITS - 1)) ? 2'd0 : mdl.cursor + 2'd1;
      else if (mdl.cursor == 2'd0) mdl.img0 = mdl.img0 ^ ~bv[6:0];
      else mdl.img1 = mdl.img1 ^ ~bv[6:0];
      sb_q.push_back(mdl);
    end
    bus.b = bv;
    repeat (ticks * TICK_CYC) begin
      @(negedge clk);
      if (bus.edit_strobe === 1'b1) begin
        total++;
        if (sb_q.size() == 0) $display("FAIL edit_strobe: unexpected pulse with b=%h", bv);
        else begin
          cur = sb_q.pop_front();
          passed++;
        end
      end
      total++;
      if (bus.cursor !== cur.cursor)
        $display("FAIL cursor: got %0d, expected %0d (b=%h)", bus.cursor, cur.cursor, bv);
      else passed++;
      total++;
`ifdef SCAN_BLANK_EN
      if (!(bus.gnd === 2'b00 || bus.gnd === 2'b01 || bus.gnd === 2'b10))
`else
      if (!(bus.gnd === 2'b01 || bus.gnd === 2'b10))
`endif
        $display("FAIL gnd_legal: got %b", bus.gnd);
      else passed++;
      if (bus.gnd === 2'b01)      exp_leds = {cur.cursor == 2'd0, cur.img0};
      else if (bus.gnd === 2'b10) exp_leds = {cur.cursor == 2'd1, cur.img1};
      else                        exp_leds = 8'h00;
      total++;
      if (bus.leds !== exp_leds)
        $display("FAIL leds: got %h, expected %h (gnd=%b b=%h)", bus.leds, exp_leds, bus.gnd, bv);
      else passed++;
    end
    total++;
    if (sb_q.size() != 0) $display("FAIL edit_missing: %0d edit(s) not seen, b=%h", sb_q.size(), bv);
    else passed++;
    sb_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (bus.gnd !== 2'b01) $display("FAIL reset_gnd: got %b, expected 01", bus.gnd);
    else passed++;
    total++;
    if (bus.leds !== 8'h80) $display("FAIL reset_leds: got %h, expected 80", bus.leds);
    else passed++;
    total++;
    if (bus.cursor !== 2'd0) $display("FAIL reset_cursor: got %0d, expected 0", bus.cursor);
    else passed++;
    total++;
    if (bus.edit_strobe !== 1'b0) $display("FAIL reset_strobe: got %b, expected 0", bus.edit_strobe);
    else passed++;
  endtask

  task automatic test_scan_idle();
    scan_t e;
    int    n;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int dg = 0; dg < DIGITS; dg++) begin
        repeat (SLOT_CYC) scan_q.push_back(scan_t'{gnd: 2'(1 << dg), leds: (dg == 0) ? 8'h80 : 8'h00});
`ifdef SCAN_BLANK_EN
        repeat (BLANK_CYC) scan_q.push_back(scan_t'{gnd: 2'b00, leds: 8'h00});
`endif
      end
    end
    n = 0;
    while (scan_q.size() > 0) begin
      e = scan_q.pop_front();
      @(negedge clk);
      total++;
      if (bus.gnd !== e.gnd || bus.leds !== e.leds || bus.edit_strobe !== 1'b0)
        $display("FAIL scan[%0d]: gnd=%b leds=%h strobe=%b, expected gnd=%b leds=%h strobe=0",
                 n, bus.gnd, bus.leds, bus.edit_strobe, e.gnd, e.leds);
      else passed++;
      n++;
    end
  endtask

  task automatic test_segment_edit();
    do_reset();
    press(8'hFE, 1'b1, 3);
    press(8'hFF, 1'b0, 1);
    press(8'hFE, 1'b1, 1);
    press(8'hFF, 1'b0, 1);
  endtask

  task automatic test_cursor_move();
    press(8'h7F, 1'b1, 1);
    press(8'hFF, 1'b0, 1);
    press(8'hFB, 1'b1, 1);
    press(8'hFF, 1'b0, 1);
  endtask

  task automatic test_invalid_presses();
    press(8'hFC, 1'b0, 1);
    press(8'h00, 1'b0, 1);
    press(8'hFD, 1'b1, 1);
    press(8'hFF, 1'b0, 1);
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * TICK_CYC && !found; i++) begin
      @(negedge clk);
`ifdef SCAN_BLANK_EN
      if (bus.gnd === 2'b00) found = 1'b1;
`else
      if (bus.gnd === 2'b10) found = 1'b1;
`endif
    end
    total++;
    if (!found) $display("FAIL mid_reset_wait: target slot not reached, gnd=%b", bus.gnd);
    else passed++;
    rst   = 1'b1;
    bus.b = 8'hFE;
    @(negedge clk);
    total++;
    if (bus.gnd !== 2'b01 || bus.leds !== 8'h80 || bus.cursor !== 2'd0 || bus.edit_strobe !== 1'b0)
      $display("FAIL mid_reset: gnd=%b leds=%h cursor=%0d strobe=%b, expected 01/80/0/0",
               bus.gnd, bus.leds, bus.cursor, bus.edit_strobe);
    else passed++;
    rst = 1'b0;
    cur = '0;
    mdl = '0;
    sb_q.delete();
    // Button held through reset counts as a fresh press at the first tick.
    press(8'hFE, 1'b1, 1);
    press(8'hFF, 1'b0, 1);
  endtask

  initial begin
    bus.b = 8'hFF;
    test_reset();
    test_scan_idle();
    test_segment_edit();
    test_cursor_move();
    test_invalid_presses();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Controller that time-multiplexes a shared 8-bit LED segment bus across up to four common-ground digits. It also edits the per-digit images from an active-low 8-button bank. It sits between the board buttons and the LED/digit-ground pins and replaces ad hoc per-design scan counters. The block sequences digit enables with optional dead-time blanking, and applies debounced, edge-qualified single-button edits to a cursor-selected image register.

## Interface
- DIGITS, 2: number of multiplexed digits; legal range 2..4.
- SLOT_CYC, 128: clock cycles each digit is driven per scan slot; must be ≥1.
- BLANK_CYC, 8: clock cycles of all-off dead time between slots; must be ≥1.
- DEB_BITS, 21: button sample period is 2^DEB_BITS cycles; must be ≥2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- b  input  8  buttons, active-low, idle 8'hFF.
- gnd  output  DIGITS  digit enables, one-hot or zero, active-high.
- leds  output  8  segment bus for the enabled digit.
- cursor  output  2  index of the digit under edit.
- edit_strobe  output  1  one-cycle pulse after each accepted press.

## Operation
- **Scan FSM** has two states, ACTIVE and BLANK, plus a digit index d and a slot counter.
  - ACTIVE: gnd = one-hot(d), leds = disp(d). After SLOT_CYC cycles the FSM goes to BLANK.
  - BLANK: gnd = 0, leds = 0. After BLANK_CYC cycles, d = (d+1) mod DIGITS and the FSM returns to ACTIVE.
  - d wraps from DIGITS-1 to 0, never through unused indices.
- **Display word:** disp(i) = {(i == cursor), img[i][6:0]}. Bit 7 is the cursor indicator.
- **Prescaler:** a DEB_BITS-wide counter wraps freely. tick is asserted when it equals 2^DEB_BITS-1.
- **Button sampling:** on tick, b is sampled.
  - A valid press means exactly one bit of b is 0 (popcount == 7).
  - An armed flag is set on any tick sample that is not a valid press.
  - A press is accepted only when the sample is a valid press and armed = 1. Acceptance clears armed, so a held button acts once.
  - Multi-button or all-released samples re-arm the flag and never edit.
- **Accepted press on b[7] (low):** cursor = (cursor+1) mod DIGITS.
- **Accepted press on b[k], k in 0..6:** img[cursor][k] toggles.
- **edit_strobe** is a registered pulse, high for exactly the one cycle after acceptance.
- **Reset values:**
  - State ACTIVE, d = 0, slot counter 0, prescaler 0.
  - cursor = 0, img[*] = 7'h00, armed = 1, edit_strobe = 0.
  - Outputs after reset: gnd = one-hot(0), leds = 8'h80, cursor = 0.

## Timing
- gnd and leds are decoded combinationally from registered state only. There is no path from b to outputs within a cycle.
- Scan period is DIGITS*(SLOT_CYC+BLANK_CYC) cycles with blanking, and DIGITS*SLOT_CYC without it.
- Edit latency: the image or cursor register updates on the tick edge. leds reflect the change from the next cycle if that digit is enabled, and edit_strobe is high in that same cycle.
- An edit landing on a slot boundary does not disturb the FSM. The new image is shown on the digit's next enabled cycle.
- A cursor advance moves the bit-7 indicator immediately; there is no wait for a slot boundary.
- Reset asserted mid-slot or mid-press restores all reset values on the next edge. A button still held after reset is treated as a new press at the first tick, because armed = 1 at reset.

## Configuration
- SCAN_BLANK_EN defined: the BLANK state is present, as described above.
- SCAN_BLANK_EN undefined:
  - The BLANK state is removed and BLANK_CYC is ignored.
  - ACTIVE of digit d is followed directly by ACTIVE of digit (d+1) mod DIGITS.
  - gnd is never all-zero after reset.

## Test plan
All scenarios use DIGITS=2, SLOT_CYC=4, BLANK_CYC=2, DEB_BITS=4 (tick every 16 cycles), with SCAN_BLANK_EN defined unless noted.

- **Reset then idle:** rst for 2 cycles, b = 8'hFF → gnd sequence 01×4, 00×2, 10×4, 00×2, repeating. leds = 8'h80 in digit-0 slots and 8'h00 in digit-1 slots.
- **Segment edit:** b = 8'hFE held across 3 ticks → img[0] = 7'h01 exactly once and one edit_strobe. Release, then press again → img[0] = 7'h00.
- **Cursor move:** b = 8'h7F for one tick, then 8'hFB for one tick → cursor = 1 and img[1] = 7'h04. Digit-1 slot shows leds = 8'h84; digit-0 slot shows 8'h00.
- **Invalid presses:** b = 8'hFC, then b = 8'h00 → no edit and no edit_strobe. Then b = 8'hFD → accepted, with img[cursor][1] toggled.
- **Mid-operation reset:** assert rst during a BLANK state after edits → next cycle gnd = 01, leds = 8'h80, cursor = 0, and all images cleared.
- **Blanking disabled:** SCAN_BLANK_EN undefined → gnd alternates 01×4, 10×4 and is never 00.
